// File: rtl/mult_seq_haleyorr2027_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_seq_haleyorr2027_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH) + 1;

  // Iteration counter width for an arbitrary operand width
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mult_seq_haleyorr2027_if.sv
// Start/busy/done handshake and operand/product bus of the multiplier.
interface mult_seq_haleyorr2027_if #(
  parameter int unsigned WIDTH = 8
);
  logic                   start;
  logic                   signed_mode;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/mult_seq_haleyorr2027_adder.sv
// WIDTH-generic ripple adder used for the per-iteration add step.
module adder_nbit_haleyorr2027 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int unsigned SW = WIDTH + 1;

  // Carry lands one bit above WIDTH
  assign {cout, sum} = SW'(a) + SW'(b);
endmodule

// File: rtl/mult_seq_haleyorr2027.sv
// Multi-cycle shift-add multiplier, one add-and-shift per clock,
// unsigned or two's-complement operands, full-width product.
module mult_seq_haleyorr2027
  import mult_seq_haleyorr2027_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mult_seq_haleyorr2027_if.slave    bus
);
  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic             neg_q;
  logic [CW-1:0]    count_q;
  logic             busy_q;
  logic             done_q;
  logic [PW-1:0]    product_q;

  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [PW-1:0]    shifted;
  logic [PW-1:0]    shifted_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             neg_in;

  // Per-iteration add of the multiplicand into the upper accumulator
  adder_nbit_haleyorr2027 #(.WIDTH(WIDTH)) u_adder (
    .a    (acc_hi_q),
    .b    (addend),
    .sum  (sum),
    .cout (cout)
  );

  // Next-state logic; start is only honoured in IDLE or DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_CALC;
      ST_CALC: if (last_iter) state_d = ST_DONE;
      ST_DONE: state_d = bus.start ? ST_CALC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath helpers: operand magnitudes, sign, add-and-shift, negation
  always_comb begin
    accept      = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    last_iter   = (count_q == CW'(WIDTH - 1));
    addend      = acc_lo_q[0] ? mcand_q : '0;
    shifted     = {cout, sum, acc_lo_q[WIDTH-1:1]};
    shifted_neg = ~shifted + PW'(1);
    mag_a       = (bus.signed_mode && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    mag_b       = (bus.signed_mode && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
    neg_in      = bus.signed_mode && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
  end

  // State, handshake outputs, accumulators and product register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      neg_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_CALC);
      done_q  <= (state_d == ST_DONE);
      if (accept) begin
        mcand_q  <= mag_a;
        acc_hi_q <= '0;
        acc_lo_q <= mag_b;
        neg_q    <= neg_in;
        count_q  <= '0;
      end else if (state_q == ST_CALC) begin
        acc_hi_q <= shifted[PW-1:WIDTH];
        acc_lo_q <= shifted[WIDTH-1:0];
        count_q  <= count_q + CW'(1);
        if (last_iter) begin
          product_q <= neg_q ? shifted_neg : shifted;
        end
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule
